// File: rtl/alu_seq_pkg.sv
// Shared op codes, FSM state type and counter sizing for the sequential ALU.
package alu_seq_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_DIV = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// Shared iterative unit: shift-add multiply, plus restoring divide when ALU_SEQ_DIV_EN is defined.
// hi_o/lo_o show the result of the current step so the caller can register the last one directly.
module alu_seq_iter
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             start_ok;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] step_hi, step_lo;
`ifdef ALU_SEQ_DIV_EN
    logic             div_q, div_d;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] rem_sub;

    assign start_ok = start_i;
`else
    // Without the divider a divide request is never a legal start.
    assign start_ok = start_i & ~div_i;
`endif

    always_comb begin
        sum     = {1'b0, acc_q} + (sh_q[0] ? {1'b0, b_q} : '0);
        step_hi = sum[WIDTH:1];
        step_lo = {sum[0], sh_q[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
        // Divisor 0 always "fits": quotient becomes all ones, remainder the dividend.
        shifted = {acc_q, sh_q[WIDTH-1]};
        rem_sub = shifted[WIDTH-1:0] - b_q;
        if (div_q) begin
            if (shifted >= {1'b0, b_q}) begin
                step_hi = rem_sub;
                step_lo = {sh_q[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = shifted[WIDTH-1:0];
                step_lo = {sh_q[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    always_comb begin
        acc_d  = acc_q;
        sh_d   = sh_q;
        b_d    = b_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
`ifdef ALU_SEQ_DIV_EN
        div_d  = div_q;
`endif
        if (start_ok) begin
            acc_d  = '0;
            sh_d   = a_i;
            b_d    = b_i;
            cnt_d  = '0;
            busy_d = 1'b1;
`ifdef ALU_SEQ_DIV_EN
            div_d  = div_i;
`endif
        end else if (busy_q) begin
            acc_d = step_hi;
            sh_d  = step_lo;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q  <= '0;
            sh_q   <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            div_q  <= 1'b0;
`endif
        end else begin
            acc_q  <= acc_d;
            sh_q   <= sh_d;
            b_q    <= b_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
`ifdef ALU_SEQ_DIV_EN
            div_q  <= div_d;
`endif
        end
    end

    assign done_o = busy_q && (cnt_q == LAST);
    assign hi_o   = step_hi;
    assign lo_o   = step_lo;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU top: FSM, handshakes, single-cycle ops and registered outputs.
// Op 101 divides only when ALU_SEQ_DIV_EN is defined; otherwise it is an illegal op.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic [2:0]       ALUCtrl_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic [WIDTH-1:0] data_hi_o,
    output logic             Zero_o,
    output logic             err_o
);
    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] data_hi_q, data_hi_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;
    logic             div_zero_q, div_zero_d;
    logic             accept, single, illegal;
    logic [WIDTH-1:0] res;
    logic             iter_start, iter_div, iter_done;
    logic [WIDTH-1:0] iter_hi, iter_lo;

    // Handshake: a transfer happens on an edge where valid & ready are both high;
    // in_ready_o is high only in IDLE, out_valid_o only in DONE, and neither
    // depends combinationally on the opposite side's valid/ready.
    assign in_ready_o = (state_q == IDLE);
    assign accept     = in_valid_i & in_ready_o;
    assign iter_div   = (ALUCtrl_i == OP_DIV);

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        data_d      = data_q;
        data_hi_d   = data_hi_q;
        zero_d      = zero_q;
        err_d       = err_q;
        div_zero_d  = div_zero_q;
        iter_start  = 1'b0;
        single      = 1'b1;
        illegal     = 1'b0;
        res         = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (ALUCtrl_i)
                        OP_ADD: res = data1_i + data2_i;
                        OP_SUB: res = data1_i - data2_i;
                        OP_AND: res = data1_i & data2_i;
                        OP_OR:  res = data1_i | data2_i;
                        OP_MUL: begin
                            single     = 1'b0;
                            div_zero_d = 1'b0;
                        end
`ifdef ALU_SEQ_DIV_EN
                        OP_DIV: begin
                            single     = 1'b0;
                            div_zero_d = (data2_i == '0);
                        end
`endif
                        default: illegal = 1'b1;
                    endcase
                    if (single) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        data_d      = res;
                        data_hi_d   = '0;
                        zero_d      = !illegal && (res == '0);
                        err_d       = illegal;
                    end else begin
                        state_d    = BUSY;
                        iter_start = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (iter_done) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    data_d      = iter_lo;
                    data_hi_d   = iter_hi;
                    zero_d      = (iter_lo == '0);
                    err_d       = div_zero_q;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            data_q      <= '0;
            data_hi_q   <= '0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            data_hi_q   <= data_hi_d;
            zero_q      <= zero_d;
            err_q       <= err_d;
            div_zero_q  <= div_zero_d;
        end
    end

    alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .start_i(iter_start),
        .div_i  (iter_div),
        .a_i    (data1_i),
        .b_i    (data2_i),
        .done_o (iter_done),
        .hi_o   (iter_hi),
        .lo_o   (iter_lo)
    );

    assign out_valid_o = out_valid_q;
    assign data_o      = data_q;
    assign data_hi_o   = data_hi_q;
    assign Zero_o      = zero_q;
    assign err_o       = err_q;

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised multi-cycle ALU for the datapath's execute stage: add, sub, and, or, and an iterative shift-add multiply, with an optional iterative divide. Operands enter through a valid/ready handshake and results leave through one. Multiply and divide run for WIDTH cycles, so the pipeline stalls on `in_ready_o` / `out_valid_o`. It keeps the existing 3-bit ALUCtrl encoding and Zero semantics and adds a high result word and an error flag.

## Interface
- `WIDTH`, 32: operand and result width in bits; legal values are 2 and above.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `in_valid_i`  in  1  operands and op are presented.
- `in_ready_o`  out  1  block can accept; high only in IDLE.
- `data1_i`  in  WIDTH  operand A.
- `data2_i`  in  WIDTH  operand B.
- `ALUCtrl_i`  in  3  op: 010 add, 110 sub, 000 and, 001 or, 100 mul, 101 div (only with the macro).
- `out_valid_o`  out  1  result is valid.
- `out_ready_i`  in  1  consumer takes the result.
- `data_o`  out  WIDTH  result: low product word for mul, quotient for div.
- `data_hi_o`  out  WIDTH  high product word for mul, remainder for div, 0 for every other op.
- `Zero_o`  out  1  `data_o == 0`.
- `err_o`  out  1  illegal op, or divide by zero.

## Operation
- States:
  - IDLE: `in_ready_o` = 1.
  - BUSY: mul/div iteration.
  - DONE: result held and `out_valid_o` = 1.
- Accept: `in_valid_i & in_ready_o` latches the operands and op.
- From IDLE, on accept:
  - add, sub, and, or, or illegal op: go to DONE on the next edge.
  - mul or div: go to BUSY with the iteration counter set to 0.
- BUSY performs one iteration per cycle. When the counter reaches WIDTH-1, the final result is registered and the state moves to DONE.
- In DONE, `out_valid_o & out_ready_i` returns the block to IDLE. Outputs hold stable while `out_ready_i` is low.
- Arithmetic:
  - add and sub are modulo 2^WIDTH; carry is discarded.
  - mul is unsigned, giving a 2·WIDTH-bit product split into {`data_hi_o`, `data_o`}.
  - div is unsigned restoring division.
- Divide by zero: `data_o` = all ones, `data_hi_o` = dividend, `err_o` = 1. It still takes WIDTH cycles.
- Illegal op (011, 111, or 101 without the macro): `data_o` = 0, `data_hi_o` = 0, `Zero_o` = 0, `err_o` = 1.
- Zero rule: for every legal op, `Zero_o` = (`data_o` == 0).
- Only one operation is in flight at a time. `in_valid_i` while not in IDLE is ignored, and the input need not be held.
- Reset at any point, including mid-BUSY or in DONE, goes to IDLE and discards the operation. No `out_valid_o` is produced for it.
- Reset values: `out_valid_o` 0, `data_o` 0, `data_hi_o` 0, `Zero_o` 0, `err_o` 0, state IDLE (so `in_ready_o` is 1 from the first cycle after reset).

## Timing
- All outputs are registered except `in_ready_o`, which is decoded directly from the state register.
- Accept at edge N:
  - single-cycle op: `out_valid_o` is high after edge N+1.
  - mul or div: `out_valid_o` is high after edge N+1+WIDTH.
- Minimum issue interval: 2 cycles for a single-cycle op, WIDTH+2 for mul or div.
- There is no combinational path from `out_ready_i` or `in_valid_i` to any output.

## Configuration
- `ALU_SEQ_DIV_EN` defined: op 101 performs the iterative unsigned divide described above, and the iterative unit includes the subtract/restore datapath.
- `ALU_SEQ_DIV_EN` undefined: op 101 is illegal and completes in one cycle with `err_o` = 1. No divider logic is synthesised.

## Structure
- Package `alu_seq_pkg` holds:
  - op code localparams: `OP_ADD`, `OP_SUB`, `OP_AND`, `OP_OR`, `OP_MUL`, `OP_DIV`.
  - the state enum: IDLE, BUSY, DONE.
  - a function computing the counter width as clog2(WIDTH).
- Sub-module `alu_seq_iter` holds the shared shift-add multiplier and restoring divider. It has the accumulator, shift registers and counter, and its ports are start, op, operands, done, hi and lo.
- `alu_seq` holds the FSM, the handshake, the single-cycle ops and the output registers.

## Test plan
- Add, WIDTH=32: add 5 + 0xFFFFFFFB, accepted at edge N → `data_o` 0, `Zero_o` 1, `err_o` 0, `out_valid_o` high after N+1. Sub 3 − 5 → 0xFFFFFFFE, `Zero_o` 0.
- Multiply: mul 0x00010000 × 0x00010000 → `data_o` 0, `data_hi_o` 1, `Zero_o` 1, `out_valid_o` after N+33. With WIDTH=8, 0xFF × 0xFF → lo 0x01, hi 0xFE.
- Backpressure: hold `out_ready_i` low for 5 cycles in DONE → outputs stable, `in_ready_o` 0, new `in_valid_i` ignored. After release the block returns to IDLE and the next op is accepted.
- Divide (with the macro): div 100 / 7 → `data_o` 14, `data_hi_o` 2. Div 100 / 0 → `data_o` 0xFFFFFFFF, `data_hi_o` 100, `err_o` 1. Without the macro, op 101 → `err_o` 1 after 1 cycle.
- Illegal op: op 011 → `data_o` 0, `Zero_o` 0, `err_o` 1.
- Reset mid-multiply: assert `rst_i` at BUSY cycle 10 → `out_valid_o` never rises for that op. `in_ready_o` is 1 on the cycle after reset and a new add completes normally.
